// File: rtl/trdb_out_arbiter.sv
// trdb_out_arbiter: merges trace and software-dump words into one FIFO toward the uDMA,
// with bounded sw starvation, stall absorption, fill level and sticky backpressure.
module trdb_out_arbiter #(
    parameter int XLEN          = 32,
    parameter int FIFO_DEPTH    = 16,
    parameter int SW_STARVE_MAX = 4
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic [XLEN-1:0]               trace_word_i,
    input  logic                          trace_valid_i,
    output logic                          trace_grant_o,
    input  logic [XLEN-1:0]               sw_word_i,
    input  logic                          sw_valid_i,
    output logic                          sw_grant_o,
    input  logic                          flush_i,
    output logic [XLEN-1:0]               word_o,
    output logic                          word_valid_o,
    input  logic                          stall_i,
    output logic [$clog2(FIFO_DEPTH):0]   fill_level_o,
    output logic                          backpressure_o,
    input  logic                          clear_bp_i
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int SW = $clog2(SW_STARVE_MAX + 1);
    localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);
    localparam logic [SW-1:0] STARVE_C = SW'(SW_STARVE_MAX);

    logic [XLEN-1:0] mem_q [FIFO_DEPTH];
    logic [XLEN-1:0] mem_d [FIFO_DEPTH];
    logic [PW-1:0]   wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [SW-1:0]   starve_q, starve_d;
    logic            bp_q, bp_d;
    logic            full, empty, can_push, push, pop, bp_set;
    logic [XLEN-1:0] push_word;

    assign full     = cnt_q == DEPTH_C;
    assign empty    = cnt_q == '0;
    // Grants are held low during reset so nothing is accepted while state is cleared.
    assign can_push = !full && !flush_i && rst_ni;

    always_comb begin
        trace_grant_o = can_push && trace_valid_i && (!sw_valid_i || starve_q < STARVE_C);
        sw_grant_o    = can_push && sw_valid_i && !trace_grant_o;
        push          = trace_grant_o || sw_grant_o;
        push_word     = trace_grant_o ? trace_word_i : sw_word_i;
        pop           = !empty && !stall_i && !flush_i;
        bp_set        = (trace_valid_i || sw_valid_i) && full && !flush_i;
        mem_d         = mem_q;
        if (push) mem_d[wptr_q] = push_word;
        wptr_d   = flush_i ? '0 : push ? wptr_q + PW'(1) : wptr_q;
        rptr_d   = flush_i ? '0 : pop ? rptr_q + PW'(1) : rptr_q;
        cnt_d    = flush_i ? '0 : cnt_q + CW'(push) - CW'(pop);
        starve_d = (flush_i || !sw_valid_i || sw_grant_o) ? '0 :
                   (trace_grant_o && starve_q < STARVE_C) ? starve_q + SW'(1) : starve_q;
        bp_d     = bp_set ? 1'b1 : clear_bp_i ? 1'b0 : bp_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mem_q    <= '{default: '0};
            wptr_q   <= '0;
            rptr_q   <= '0;
            cnt_q    <= '0;
            starve_q <= '0;
            bp_q     <= 1'b0;
        end else begin
            mem_q    <= mem_d;
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            cnt_q    <= cnt_d;
            starve_q <= starve_d;
            bp_q     <= bp_d;
        end
    end

    assign word_valid_o   = !empty;
    assign word_o         = empty ? '0 : mem_q[rptr_q];
    assign fill_level_o   = cnt_q;
    assign backpressure_o = bp_q;
endmodule

// File: tb/tb_trdb_out_arbiter.sv
// tb_trdb_out_arbiter: directed vector table plus hand-written multi-cycle sequences
// for starvation pattern, full/stall, flush and asynchronous reset.
module tb_trdb_out_arbiter;
    logic        clk_i = 0, rst_ni = 0;
    logic [31:0] trace_word_i = 0, sw_word_i = 0;
    logic        trace_valid_i = 0, sw_valid_i = 0, flush_i = 0, stall_i = 0, clear_bp_i = 0;
    logic        trace_grant_o, sw_grant_o, word_valid_o, backpressure_o;
    logic [31:0] word_o;
    logic [4:0]  fill_level_o;
    int          n_chk = 0, n_fail = 0;

    trdb_out_arbiter dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .trace_word_i(trace_word_i), .trace_valid_i(trace_valid_i), .trace_grant_o(trace_grant_o),
        .sw_word_i(sw_word_i), .sw_valid_i(sw_valid_i), .sw_grant_o(sw_grant_o),
        .flush_i(flush_i), .word_o(word_o), .word_valid_o(word_valid_o), .stall_i(stall_i),
        .fill_level_o(fill_level_o), .backpressure_o(backpressure_o), .clear_bp_i(clear_bp_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic tv; logic [31:0] tw; logic sv; logic [31:0] sw;
        logic stall; logic flush; logic clr;
        logic tg; logic sg; logic wv; logic [31:0] wo; logic [4:0] fill; logic bp;
    } vec_t;

    vec_t        vecs[$];
    logic [31:0] got[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive(input logic tv, input logic [31:0] tw, input logic sv, input logic [31:0] sw,
                         input logic stall, input logic flush, input logic clr);
        trace_valid_i = tv; trace_word_i = tw; sw_valid_i = sv; sw_word_i = sw;
        stall_i = stall; flush_i = flush; clear_bp_i = clr;
    endtask

    initial begin
        // reset state, with a pending trace word that must not be granted
        trace_valid_i = 1;
        #3;
        chk("rst_tg", trace_grant_o, 0);
        chk("rst_wv", word_valid_o, 0);
        chk("rst_wo", word_o, 0);
        chk("rst_fill", fill_level_o, 0);
        chk("rst_bp", backpressure_o, 0);
        trace_valid_i = 0;
        repeat (2) @(posedge clk_i);
        #1 rst_ni = 1;

        //               tv tw     sv sw     st fl cl  tg sg wv wo     fill bp
        vecs.push_back('{1, 32'h1, 0, 32'h0, 0, 0, 0,  1, 0, 0, 32'h0, 0, 0});
        vecs.push_back('{1, 32'h2, 0, 32'h0, 0, 0, 0,  1, 0, 1, 32'h1, 1, 0});
        vecs.push_back('{1, 32'h3, 0, 32'h0, 0, 0, 0,  1, 0, 1, 32'h2, 1, 0});
        vecs.push_back('{1, 32'h4, 0, 32'h0, 0, 0, 0,  1, 0, 1, 32'h3, 1, 0});
        vecs.push_back('{1, 32'h5, 0, 32'h0, 0, 0, 0,  1, 0, 1, 32'h4, 1, 0});
        vecs.push_back('{0, 32'h0, 0, 32'h0, 0, 0, 0,  0, 0, 1, 32'h5, 1, 0});
        vecs.push_back('{0, 32'h0, 0, 32'h0, 0, 0, 0,  0, 0, 0, 32'h0, 0, 0});
        vecs.push_back('{0, 32'h0, 1, 32'hA, 0, 0, 0,  0, 1, 0, 32'h0, 0, 0});
        vecs.push_back('{0, 32'h0, 0, 32'h0, 0, 0, 0,  0, 0, 1, 32'hA, 1, 0});
        vecs.push_back('{0, 32'h0, 0, 32'h0, 0, 0, 0,  0, 0, 0, 32'h0, 0, 0});
        vecs.push_back('{1, 32'h10, 1, 32'hB, 1, 0, 0, 1, 0, 0, 32'h0, 0, 0});
        vecs.push_back('{1, 32'h11, 1, 32'hB, 1, 0, 0, 1, 0, 1, 32'h10, 1, 0});
        vecs.push_back('{1, 32'h12, 1, 32'hB, 1, 0, 0, 1, 0, 1, 32'h10, 2, 0});
        vecs.push_back('{1, 32'h13, 1, 32'hB, 1, 0, 0, 1, 0, 1, 32'h10, 3, 0});
        vecs.push_back('{1, 32'h14, 1, 32'hB, 1, 0, 0, 0, 1, 1, 32'h10, 4, 0});
        vecs.push_back('{1, 32'h14, 1, 32'hC, 1, 0, 0, 1, 0, 1, 32'h10, 5, 0});
        vecs.push_back('{1, 32'h15, 1, 32'hC, 0, 1, 0, 0, 0, 1, 32'h10, 6, 0});
        vecs.push_back('{0, 32'h0, 0, 32'h0, 0, 0, 0,  0, 0, 0, 32'h0, 0, 0});
        foreach (vecs[i]) begin
            drive(vecs[i].tv, vecs[i].tw, vecs[i].sv, vecs[i].sw, vecs[i].stall, vecs[i].flush, vecs[i].clr);
            @(negedge clk_i);
            chk($sformatf("v%0d_tg", i), trace_grant_o, vecs[i].tg);
            chk($sformatf("v%0d_sg", i), sw_grant_o, vecs[i].sg);
            chk($sformatf("v%0d_wv", i), word_valid_o, vecs[i].wv);
            chk($sformatf("v%0d_wo", i), word_o, vecs[i].wo);
            chk($sformatf("v%0d_fill", i), fill_level_o, vecs[i].fill);
            chk($sformatf("v%0d_bp", i), backpressure_o, vecs[i].bp);
            next_cycle();
        end

        // both sources always valid: 4 trace grants then 1 sw grant, repeating
        begin
            int tc = 0, sc = 0;
            got.delete();
            for (int c = 0; c < 15; c++) begin
                drive(1, 32'h100 + tc, 1, 32'h200 + sc, 0, 0, 0);
                @(negedge clk_i);
                chk($sformatf("pat%0d_tg", c), trace_grant_o, (c % 5 != 4));
                chk($sformatf("pat%0d_sg", c), sw_grant_o, (c % 5 == 4));
                if (word_valid_o) got.push_back(word_o);
                if (trace_grant_o) tc++;
                if (sw_grant_o) sc++;
                next_cycle();
            end
            drive(0, 0, 0, 0, 0, 0, 0);
            for (int c = 0; c < 5; c++) begin
                @(negedge clk_i);
                if (word_valid_o) got.push_back(word_o);
                next_cycle();
            end
            chk("pat_count", got.size(), 15);
            foreach (got[i])
                chk($sformatf("pat_word%0d", i), got[i],
                    (i % 5 == 4) ? 32'h200 + i / 5 : 32'h100 + i - i / 5);
        end

        // stalled trace source fills the FIFO, then backpressure and release
        begin
            int ng = 0;
            for (int c = 0; c < 20; c++) begin
                drive(1, 32'h300 + ng, 0, 0, 1, 0, 0);
                @(negedge clk_i);
                if (trace_grant_o) ng++;
                next_cycle();
            end
            chk("stall_grants", ng, 16);
            drive(1, 32'h310, 0, 0, 1, 0, 1);
            @(negedge clk_i);
            chk("full_tg", trace_grant_o, 0);
            chk("full_fill", fill_level_o, 16);
            chk("full_bp", backpressure_o, 1);
            next_cycle();
            got.delete();
            drive(1, 32'h310, 0, 0, 0, 0, 0);
            @(negedge clk_i);
            chk("fullpop_tg", trace_grant_o, 0);
            chk("fullpop_fill", fill_level_o, 16);
            chk("bp_set_over_clr", backpressure_o, 1);
            if (word_valid_o) got.push_back(word_o);
            next_cycle();
            @(negedge clk_i);
            chk("resume_fill", fill_level_o, 15);
            chk("resume_tg", trace_grant_o, 1);
            if (word_valid_o) got.push_back(word_o);
            next_cycle();
            drive(0, 0, 0, 0, 0, 0, 0);
            for (int c = 0; c < 20; c++) begin
                @(negedge clk_i);
                if (word_valid_o) got.push_back(word_o);
                next_cycle();
            end
            chk("drain_count", got.size(), 17);
            foreach (got[i]) chk($sformatf("drain_word%0d", i), got[i], 32'h300 + i);
        end

        // flush with fill level 7 while both sources request; backpressure survives
        for (int c = 0; c < 7; c++) begin
            drive(1, 32'h400 + c, 0, 0, 1, 0, 0);
            next_cycle();
        end
        drive(1, 32'h407, 1, 32'h4FF, 0, 1, 0);
        @(negedge clk_i);
        chk("flush_tg", trace_grant_o, 0);
        chk("flush_sg", sw_grant_o, 0);
        chk("flush_fill_before", fill_level_o, 7);
        next_cycle();
        drive(0, 0, 0, 0, 0, 0, 0);
        @(negedge clk_i);
        chk("flush_wv", word_valid_o, 0);
        chk("flush_fill", fill_level_o, 0);
        chk("flush_bp_kept", backpressure_o, 1);
        next_cycle();
        drive(0, 0, 0, 0, 0, 0, 1);
        next_cycle();
        drive(0, 0, 0, 0, 0, 0, 0);
        @(negedge clk_i);
        chk("bp_cleared", backpressure_o, 0);
        next_cycle();

        // asynchronous reset mid-burst at fill level 9
        for (int c = 0; c < 9; c++) begin
            drive(1, 32'h500 + c, 0, 0, 1, 0, 0);
            next_cycle();
        end
        @(negedge clk_i);
        chk("prerst_fill", fill_level_o, 9);
        #2 rst_ni = 0;
        #1;
        chk("arst_wv", word_valid_o, 0);
        chk("arst_wo", word_o, 0);
        chk("arst_fill", fill_level_o, 0);
        chk("arst_tg", trace_grant_o, 0);
        next_cycle();
        rst_ni = 1;
        drive(1, 32'h600, 0, 0, 0, 0, 0);
        @(negedge clk_i);
        chk("postrst_tg", trace_grant_o, 1);
        next_cycle();
        drive(0, 0, 0, 0, 0, 0, 0);
        @(negedge clk_i);
        chk("postrst_wv", word_valid_o, 1);
        chk("postrst_wo", word_o, 32'h600);
        next_cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
